// File: rtl/digital_pll_sequencer.sv
// rtl/digital_pll_sequencer.sv - startup/shutdown sequencer for the digital PLL
module digital_pll_sequencer #(
  parameter int WAIT_W      = 16,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              cfg_start,
  input  logic              cfg_dco,
  input  logic [4:0]        cfg_div,
  input  logic [25:0]       cfg_trim,
  input  logic [7:0]        cfg_ramp_interval,
  input  logic [WAIT_W-1:0] cfg_settle,
  input  logic              sel_ack,
  output logic              pll_enable,
  output logic              pll_resetb,
  output logic              pll_dco,
  output logic [4:0]        pll_div,
  output logic [25:0]       pll_trim,
  output logic              sel_pll,
  output logic              ready,
  output logic              fault,
  output logic [2:0]        state
);

  // One shared in-state counter must cover the settle count, the ack
  // timeout and the ramp interval.
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int MAX_A = (WAIT_W > TO_W) ? WAIT_W : TO_W;
  localparam int CNT_W = (MAX_A > 8) ? MAX_A : 8;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_RESET    = 3'd1,
    S_RAMP     = 3'd2,
    S_SETTLE   = 3'd3,
    S_SWITCH   = 3'd4,
    S_RUN      = 3'd5,
    S_UNSWITCH = 3'd6,
    S_FAULT    = 3'd7
  } state_t;

  state_t cur, nxt;

  logic              dco_q;
  logic [4:0]        div_q;
  logic [25:0]       trim_q;
  logic [7:0]        ramp_q;
  logic [WAIT_W-1:0] settle_q;
  logic [CNT_W-1:0]  cnt;
  logic [25:0]       mask;

  logic [WAIT_W-1:0] settle_last;
  logic              ramp_tick;
  logic              timeout;

  // A settle value of 0 behaves like 1, so the last count is 0 either way
  assign settle_last = (settle_q == '0) ? '0 : settle_q - 1'b1;
  assign ramp_tick   = (cnt == CNT_W'(ramp_q));
  assign timeout     = (cnt == CNT_W'(ACK_TIMEOUT - 1));

  assign state = cur;

  logic              enable_d;
  logic              resetb_d;
  logic              dco_d;
  logic [4:0]        div_d;
  logic [25:0]       trim_d;
  logic              sel_d;
  logic              ready_d;
  logic              fault_d;

  // State register
  always_ff @(posedge clock) begin
    if (!resetb) cur <= S_OFF;
    else         cur <= nxt;
  end

  // Next-state logic; ack is looked at before a dropped start request
  always_comb begin
    nxt = cur;
    case (cur)
      S_OFF:      if (cfg_start) nxt = S_RESET;
      S_RESET: begin
        if (!cfg_start)               nxt = S_OFF;
        else if (cnt == CNT_W'(3))    nxt = dco_q ? S_RAMP : S_SETTLE;
      end
      S_RAMP: begin
        if (!cfg_start)               nxt = S_OFF;
        else if (&mask)               nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (!cfg_start)                         nxt = S_OFF;
        else if (cnt == CNT_W'(settle_last))    nxt = S_SWITCH;
      end
      S_SWITCH: begin
        if (sel_ack)                  nxt = S_RUN;
        else if (!cfg_start)          nxt = S_UNSWITCH;
        else if (timeout)             nxt = S_FAULT;
      end
      S_RUN:      if (!cfg_start) nxt = S_UNSWITCH;
      S_UNSWITCH: begin
        if (!sel_ack)                 nxt = S_OFF;
        else if (timeout)             nxt = S_FAULT;
      end
      S_FAULT:    if (!cfg_start) nxt = S_OFF;
      default:    nxt = S_OFF;
    endcase
  end

  // Output decode from the current state and latched config
  always_comb begin
    enable_d = 1'b0;
    resetb_d = 1'b0;
    dco_d    = 1'b0;
    div_d    = 5'd0;
    trim_d   = 26'd0;
    sel_d    = 1'b0;
    ready_d  = 1'b0;
    fault_d  = 1'b0;
    case (cur)
      S_RESET: begin
        enable_d = 1'b1;
        dco_d    = dco_q;
        div_d    = div_q;
        trim_d   = trim_q & mask;
      end
      S_RAMP, S_SETTLE, S_SWITCH, S_RUN, S_UNSWITCH: begin
        enable_d = 1'b1;
        resetb_d = 1'b1;
        dco_d    = dco_q;
        div_d    = div_q;
        trim_d   = trim_q & mask;
        sel_d    = (cur == S_SWITCH) || (cur == S_RUN);
        ready_d  = (cur == S_RUN);
      end
      S_FAULT:  fault_d = 1'b1;
      default:  ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clock) begin
    if (!resetb) begin
      pll_enable <= 1'b0;
      pll_resetb <= 1'b0;
      pll_dco    <= 1'b0;
      pll_div    <= 5'd0;
      pll_trim   <= 26'd0;
      sel_pll    <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      pll_enable <= enable_d;
      pll_resetb <= resetb_d;
      pll_dco    <= dco_d;
      pll_div    <= div_d;
      pll_trim   <= trim_d;
      sel_pll    <= sel_d;
      ready      <= ready_d;
      fault      <= fault_d;
    end
  end

  // Config capture at start, in-state counter and trim ramp mask
  always_ff @(posedge clock) begin
    if (!resetb) begin
      dco_q    <= 1'b0;
      div_q    <= 5'd0;
      trim_q   <= 26'd0;
      ramp_q   <= 8'd0;
      settle_q <= '0;
      cnt      <= '0;
      mask     <= 26'd0;
    end else begin
      if (cur == S_OFF && cfg_start) begin
        dco_q    <= cfg_dco;
        div_q    <= cfg_div;
        trim_q   <= cfg_trim;
        ramp_q   <= cfg_ramp_interval;
        settle_q <= cfg_settle;
      end
      if (nxt != cur)                   cnt <= '0;
      else if (cur == S_RAMP && ramp_tick) cnt <= '0;
      else                              cnt <= cnt + CNT_W'(1);
      case (cur)
        S_OFF, S_RESET: mask <= 26'd0;
        S_RAMP:         if (ramp_tick) mask <= {mask[24:0], 1'b1};
        default:        ;
      endcase
    end
  end

endmodule

// File: tb/tb_digital_pll_sequencer.sv
// tb/tb_digital_pll_sequencer.sv - directed self-checking bench for digital_pll_sequencer
module tb_digital_pll_sequencer;

  logic        clock = 1'b0;
  logic        resetb;
  logic        cfg_start;
  logic        cfg_dco;
  logic [4:0]  cfg_div;
  logic [25:0] cfg_trim;
  logic [7:0]  cfg_ramp_interval;
  logic [15:0] cfg_settle;
  logic        sel_ack;
  logic        pll_enable;
  logic        pll_resetb;
  logic        pll_dco;
  logic [4:0]  pll_div;
  logic [25:0] pll_trim;
  logic        sel_pll;
  logic        ready;
  logic        fault;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  digital_pll_sequencer #(.WAIT_W(16), .ACK_TIMEOUT(8)) dut (
    .clock(clock), .resetb(resetb), .cfg_start(cfg_start), .cfg_dco(cfg_dco),
    .cfg_div(cfg_div), .cfg_trim(cfg_trim), .cfg_ramp_interval(cfg_ramp_interval),
    .cfg_settle(cfg_settle), .sel_ack(sel_ack), .pll_enable(pll_enable),
    .pll_resetb(pll_resetb), .pll_dco(pll_dco), .pll_div(pll_div),
    .pll_trim(pll_trim), .sel_pll(sel_pll), .ready(ready), .fault(fault),
    .state(state)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetb = 1'b0; cfg_start = 1'b0; cfg_dco = 1'b0; cfg_div = 5'd0;
    cfg_trim = 26'd0; cfg_ramp_interval = 8'd0; cfg_settle = 16'd0; sel_ack = 1'b0;
    step(2);
    resetb = 1'b1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_enable", 32'(pll_enable), 32'd0);
    chk("rst_resetb", 32'(pll_resetb), 32'd0);
    chk("rst_sel", 32'(sel_pll), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_div", 32'(pll_div), 32'd0);
    chk("rst_trim", 32'(pll_trim), 32'd0);

    // FLL start, ack 3 cycles after sel_pll, then shutdown
    cfg_dco = 1'b0; cfg_div = 5'd9; cfg_trim = 26'h123456; cfg_settle = 16'd10;
    cfg_start = 1'b1;
    step(1);  // edge 0
    chk("fll_e0_state", 32'(state), 32'd1);
    chk("fll_e0_enable", 32'(pll_enable), 32'd0);
    step(1);  // edge 1
    chk("fll_e1_enable", 32'(pll_enable), 32'd1);
    chk("fll_e1_resetb", 32'(pll_resetb), 32'd0);
    chk("fll_e1_div", 32'(pll_div), 32'd9);
    chk("fll_e1_dco", 32'(pll_dco), 32'd0);
    step(3);  // edge 4
    chk("fll_e4_state", 32'(state), 32'd3);
    chk("fll_e4_resetb", 32'(pll_resetb), 32'd0);
    step(1);  // edge 5
    chk("fll_e5_resetb", 32'(pll_resetb), 32'd1);
    chk("fll_e5_trim", 32'(pll_trim), 32'd0);
    step(9);  // edge 14
    chk("fll_e14_state", 32'(state), 32'd4);
    chk("fll_e14_sel", 32'(sel_pll), 32'd0);
    step(1);  // edge 15
    chk("fll_e15_sel", 32'(sel_pll), 32'd1);
    step(2);  // edge 17
    sel_ack = 1'b1;
    step(1);  // edge 18
    chk("fll_e18_state", 32'(state), 32'd5);
    chk("fll_e18_ready", 32'(ready), 32'd0);
    step(1);  // edge 19
    chk("fll_e19_ready", 32'(ready), 32'd1);
    chk("fll_e19_trim", 32'(pll_trim), 32'd0);
    cfg_start = 1'b0;
    step(1);  // edge 20
    chk("shut_e20_state", 32'(state), 32'd6);
    step(1);  // edge 21
    chk("shut_e21_sel", 32'(sel_pll), 32'd0);
    chk("shut_e21_enable", 32'(pll_enable), 32'd1);
    chk("shut_e21_ready", 32'(ready), 32'd0);
    sel_ack = 1'b0;
    step(1);  // edge 22
    chk("shut_e22_state", 32'(state), 32'd0);
    chk("shut_e22_enable", 32'(pll_enable), 32'd1);
    step(1);  // edge 23
    chk("shut_e23_enable", 32'(pll_enable), 32'd0);
    chk("shut_e23_div", 32'(pll_div), 32'd0);

    // DCO ramp, interval 1, then ack timeout into FAULT
    cfg_dco = 1'b1; cfg_div = 5'd17; cfg_trim = 26'h3FFFFFF;
    cfg_ramp_interval = 8'd1; cfg_settle = 16'd2;
    cfg_start = 1'b1;
    step(1);  // edge 0
    chk("dco_e0_state", 32'(state), 32'd1);
    cfg_trim = 26'd0; cfg_dco = 1'b0;  // ignored outside OFF
    step(4);  // edge 4
    chk("dco_e4_state", 32'(state), 32'd2);
    step(1);  // edge 5
    chk("dco_e5_resetb", 32'(pll_resetb), 32'd1);
    chk("dco_e5_dco", 32'(pll_dco), 32'd1);
    chk("dco_e5_trim", 32'(pll_trim), 32'd0);
    step(1);  // edge 6
    chk("dco_e6_trim", 32'(pll_trim), 32'd0);
    step(1);  // edge 7
    chk("dco_e7_trim", 32'(pll_trim), 32'd1);
    step(1);  // edge 8
    chk("dco_e8_trim", 32'(pll_trim), 32'd1);
    step(1);  // edge 9
    chk("dco_e9_trim", 32'(pll_trim), 32'd3);
    step(2);  // edge 11
    chk("dco_e11_trim", 32'(pll_trim), 32'd7);
    step(45); // edge 56
    chk("dco_e56_state", 32'(state), 32'd2);
    chk("dco_e56_trim", 32'(pll_trim), 32'h1FFFFFF);
    step(1);  // edge 57
    chk("dco_e57_state", 32'(state), 32'd3);
    chk("dco_e57_trim", 32'(pll_trim), 32'h3FFFFFF);
    step(2);  // edge 59
    chk("to_e59_state", 32'(state), 32'd4);
    step(7);  // edge 66
    chk("to_e66_state", 32'(state), 32'd4);
    chk("to_e66_sel", 32'(sel_pll), 32'd1);
    step(1);  // edge 67
    chk("to_e67_state", 32'(state), 32'd7);
    step(1);  // edge 68
    chk("to_e68_fault", 32'(fault), 32'd1);
    chk("to_e68_enable", 32'(pll_enable), 32'd0);
    chk("to_e68_sel", 32'(sel_pll), 32'd0);
    chk("to_e68_dco", 32'(pll_dco), 32'd0);
    cfg_start = 1'b0;
    step(1);  // edge 69
    chk("to_e69_state", 32'(state), 32'd0);
    step(1);  // edge 70
    chk("to_e70_fault", 32'(fault), 32'd0);

    // Abort mid-RAMP
    cfg_dco = 1'b1; cfg_trim = 26'h2AAAAAA; cfg_ramp_interval = 8'd0;
    cfg_start = 1'b1;
    step(5);  // edge 4
    chk("ab_e4_state", 32'(state), 32'd2);
    step(6);  // edge 10
    chk("ab_e10_trim", 32'(pll_trim), 32'h0A);
    cfg_start = 1'b0;
    step(1);  // edge 11
    chk("ab_e11_state", 32'(state), 32'd0);
    step(1);  // edge 12
    chk("ab_e12_trim", 32'(pll_trim), 32'd0);
    chk("ab_e12_enable", 32'(pll_enable), 32'd0);

    // Settle 0 lasts one cycle, then reset while in RUN
    cfg_dco = 1'b0; cfg_settle = 16'd0;
    cfg_start = 1'b1;
    step(5);  // edge 4
    chk("s0_e4_state", 32'(state), 32'd3);
    step(1);  // edge 5
    chk("s0_e5_state", 32'(state), 32'd4);
    sel_ack = 1'b1;
    step(1);  // edge 6
    chk("s0_e6_state", 32'(state), 32'd5);
    step(1);  // edge 7
    chk("s0_e7_ready", 32'(ready), 32'd1);
    resetb = 1'b0;
    step(1);  // edge 8
    chk("rr_state", 32'(state), 32'd0);
    chk("rr_ready", 32'(ready), 32'd0);
    chk("rr_enable", 32'(pll_enable), 32'd0);
    chk("rr_sel", 32'(sel_pll), 32'd0);
    chk("rr_resetb", 32'(pll_resetb), 32'd0);
    cfg_start = 1'b0; sel_ack = 1'b0;
    resetb = 1'b1;
    step(1);

    // Ack and start drop on the same SWITCH edge: RUN first, then UNSWITCH
    cfg_start = 1'b1;
    step(6);  // edge 5
    chk("sim_e5_state", 32'(state), 32'd4);
    sel_ack = 1'b1; cfg_start = 1'b0;
    step(1);  // edge 6
    chk("sim_e6_state", 32'(state), 32'd5);
    step(1);  // edge 7
    chk("sim_e7_state", 32'(state), 32'd6);
    sel_ack = 1'b0;
    step(1);  // edge 8
    chk("sim_e8_state", 32'(state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digital_pll_sequencer.md
# digital_pll_sequencer

Startup/shutdown sequencer for the digital PLL. It runs on the external oscillator clock and drives the PLL's enable, reset, DCO-mode, divider and external trim inputs. In DCO mode it ramps the trim gradually, then waits for the PLL to settle. It then hands the core clock over to the PLL through a request/acknowledge handshake with the clock-select mux, and reverses the sequence on shutdown.

## Interface
Parameters:
- WAIT_W, 16, width of the settle counter
- ACK_TIMEOUT, 1023, cycles to wait for `sel_ack` before faulting (≥1)

Ports:
- clock  in  1  external oscillator clock; the only clock
- resetb  in  1  synchronous, active-low reset
- cfg_start  in  1  level request: 1 = PLL clock wanted, 0 = shut down
- cfg_dco  in  1  1 = DCO mode (external trim), 0 = FLL mode
- cfg_div  in  5  feedback divider, latched at start
- cfg_trim  in  26  DCO target trim, latched at start
- cfg_ramp_interval  in  8  cycles per ramp step, minus 1
- cfg_settle  in  WAIT_W  settle cycles; 0 is treated as 1
- sel_ack  in  1  clock mux status: 1 = core running on PLL clock (already synchronized to `clock`)
- pll_enable  out  1  to PLL `enable`
- pll_resetb  out  1  to PLL `resetb`
- pll_dco  out  1  to PLL `dco`
- pll_div  out  5  to PLL `div`
- pll_trim  out  26  to PLL `ext_trim`
- sel_pll  out  1  clock-select request to mux
- ready  out  1  high only in RUN
- fault  out  1  high only in FAULT
- state  out  3  current state encoding

## Operation
- Reset (`resetb`=0 at a clock edge):
  - State goes to OFF.
  - All outputs and internal counters go to 0.
  - The latched `cfg_div` and `cfg_trim` values are cleared.
- All outputs are registered and decoded from state and latched config.
- States and encodings: OFF=0, RESET=1, RAMP=2, SETTLE=3, SWITCH=4, RUN=5, UNSWITCH=6, FAULT=7.
- OFF:
  - `pll_enable`=0, `pll_resetb`=0, `sel_pll`=0, `pll_trim`=0.
  - If `cfg_start`=1: latch `cfg_dco`, `cfg_div`, `cfg_trim` and go to RESET.
- RESET:
  - `pll_enable`=1, `pll_resetb`=0.
  - Lasts exactly 4 cycles, then goes to RAMP if the latched dco bit is 1, else SETTLE.
- RAMP (DCO mode only):
  - `pll_resetb`=1; `pll_trim` = latched trim AND mask.
  - Mask is 0 on entry. Every `cfg_ramp_interval`+1 cycles, a 1 is shifted in from the LSB (mask = {mask[24:0],1}).
  - The cycle after the mask reaches all-ones, go to SETTLE.
- SETTLE:
  - `pll_resetb`=1; `pll_trim` holds its final value (0 in FLL mode).
  - Counts max(`cfg_settle`,1) cycles, then goes to SWITCH.
- SWITCH:
  - `sel_pll`=1.
  - `sel_ack`=1 → RUN.
  - ACK_TIMEOUT cycles spent in SWITCH without ack → FAULT.
- RUN: `ready`=1. `cfg_start`=0 → UNSWITCH.
- UNSWITCH:
  - `sel_pll`=0; the PLL stays enabled.
  - `sel_ack`=0 → OFF.
  - ACK_TIMEOUT cycles spent in UNSWITCH without `sel_ack` falling → FAULT.
- FAULT:
  - `pll_enable`=0, `pll_resetb`=0, `sel_pll`=0, `fault`=1.
  - `cfg_start`=0 → OFF.
- Abort:
  - `cfg_start`=0 in RESET, RAMP or SETTLE → OFF on the next edge.
  - `cfg_start`=0 in SWITCH → UNSWITCH.
- Config inputs other than `cfg_start` are ignored outside OFF; they are re-sampled only on the next start.
- The `pll_dco` and `pll_div` outputs hold their latched values from RESET until the block returns to OFF; they are 0 in OFF and FAULT.

## Timing
- `cfg_start` rises and is sampled at edge 0:
  - `pll_enable`=1 after edge 1.
  - `pll_resetb`=1 after edge 5.
- DCO mode:
  - RAMP occupies 26×(`cfg_ramp_interval`+1)+1 cycles.
  - Mask bit k is set after k+1 intervals.
- `sel_pll` rises max(`cfg_settle`,1) cycles after SETTLE entry.
- `ready` rises 1 cycle after `sel_ack`=1 is sampled.
- Timeout: fires on the edge where the in-state counter equals ACK_TIMEOUT−1 with no ack. The counter restarts on every state entry.
- `sel_ack` and `cfg_start` changing on the same edge: `sel_ack` is evaluated first.
  - In SWITCH, if `sel_ack`=1 and `cfg_start`=0 on the same edge, go to RUN; UNSWITCH follows next cycle.
- `resetb` low during any state overrides everything on that edge.

## Test plan
- FLL start:
  - Stimulus: `cfg_dco`=0, `cfg_settle`=10, `cfg_start` 0→1, `sel_ack` returned 3 cycles after `sel_pll`.
  - Response: `pll_enable` at cycle 1, `pll_resetb` at cycle 5, `sel_pll` at cycle 15, `ready` at cycle 19, `pll_trim`=0 throughout.
- DCO ramp:
  - Stimulus: `cfg_dco`=1, `cfg_trim`=26'h3FFFFFF, `cfg_ramp_interval`=1.
  - Response: `pll_trim` goes 0, 1, 3, 7, … changing every 2 cycles and reaches 26'h3FFFFFF after 52 cycles in RAMP; then SETTLE.
- Ack timeout:
  - Stimulus: ACK_TIMEOUT=8, `sel_ack` held 0.
  - Response: FAULT after 8 SWITCH cycles with `fault`=1, `pll_enable`=0. `cfg_start`=0 → OFF, `fault`=0.
- Shutdown:
  - Stimulus: in RUN, drop `cfg_start`; `sel_ack` falls 2 cycles later.
  - Response: `sel_pll`=0 at the next edge, `pll_enable` stays 1 until OFF, then 0.
- Abort and reset:
  - Stimulus: drop `cfg_start` mid-RAMP.
  - Response: OFF on the next edge, `pll_trim`=0.
  - Stimulus: assert `resetb`=0 in RUN.
  - Response: all outputs 0 after one edge.
- Settle 0:
  - Stimulus: `cfg_settle`=0.
  - Response: SETTLE lasts exactly 1 cycle.
